fib_sink: RTL and testbench

Consumer end of the Fibonacci term stream. Requests terms from the Fibonacci generator with a one-cycle `f_en` pulse and captures each returned `f_out` on `f_valid`. Checks every term against its own recomputed sequence and presents the last good term, a term index and status flags to the display logic downstream. Stops cleanly after the last term that fits in 16 bits.

---
 rtl/fib_sink.sv | 168 ++++++++++++++++
 tb/tb_fib_sink.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_sink.sv
`default_nettype none
// ============================================================================
// Module      : fib_sink
// Description : Consumer end of the Fibonacci term stream. Requests one term
//               per f_en pulse and checks each returned value against a local
//               recomputation of the sequence. Presents the last good term,
//               its index and status flags. Stops after index 24 (46368), the
//               last term that fits in 16 bits.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               start              - level; (re)starts a run from IDLE/DONE/ERR
//               f_valid, f_out     - term strobe and value from the generator
//               f_en               - one-cycle request pulse to the generator
//               term, term_idx     - last accepted term and its index
//               term_strobe        - pulses when term/term_idx update
//               busy, done         - run in progress / run complete
//               seq_err            - ERR caused by a value mismatch
//               timeout_err        - ERR caused by a missing response
//               proto_err          - sticky; spurious f_valid seen
// Revision    : 1.0 - initial release
// ============================================================================
module fib_sink #(
   parameter int PACE_CYCLES    = 5_000_000,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        f_valid,
   input  logic [15:0] f_out,
   output logic        f_en,
   output logic [15:0] term,
   output logic [4:0]  term_idx,
   output logic        term_strobe,
   output logic        busy,
   output logic        done,
   output logic        seq_err,
   output logic        timeout_err,
   output logic        proto_err
);

   // One shared counter serves both PACE and WAIT, so it is sized for the
   // larger of the two limits.
   localparam int c_CNT_MAX = (PACE_CYCLES > TIMEOUT_CYCLES) ? PACE_CYCLES : TIMEOUT_CYCLES;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

   localparam logic [c_CNT_W-1:0] c_PACE_LAST = c_CNT_W'(PACE_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_TMO_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
   localparam logic [4:0]         c_LAST_IDX  = 5'd24;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PACE = 3'd1;
   localparam logic [2:0] S_REQ  = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;

   logic [2:0]         r_state;
   logic [16:0]        r_exp_a;
   logic [16:0]        r_exp_b;
   logic [c_CNT_W-1:0] r_cnt;
   logic [4:0]         r_acc;
   logic [15:0]        r_term;
   logic [4:0]         r_term_idx;
   logic               r_strobe;
   logic               r_seq;
   logic               r_tmo;
   logic               r_proto;

   logic [16:0]        w_sum;
   logic               w_match;

   assign w_sum   = r_exp_a + r_exp_b;
   // f_out is zero-extended, so an expected value with bit 16 set can never
   // match: overflow surfaces as a sequence error instead of wrapping.
   assign w_match = ({1'b0, f_out} == r_exp_a);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_exp_a    <= 17'd0;
         r_exp_b    <= 17'd1;
         r_cnt      <= '0;
         r_acc      <= 5'd0;
         r_term     <= 16'd0;
         r_term_idx <= 5'd0;
         r_strobe   <= 1'b0;
         r_seq      <= 1'b0;
         r_tmo      <= 1'b0;
         r_proto    <= 1'b0;
      end else begin
         r_strobe <= 1'b0;

         // A valid outside WAIT (including the REQ cycle itself) is a
         // protocol violation; it is flagged but has no other effect.
         if (f_valid && (r_state != S_WAIT)) begin
            r_proto <= 1'b1;
         end

         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  r_state <= S_REQ;
                  r_exp_a <= 17'd0;
                  r_exp_b <= 17'd1;
                  r_acc   <= 5'd0;
                  r_seq   <= 1'b0;
                  r_tmo   <= 1'b0;
                  r_proto <= 1'b0;
               end
            end

            S_REQ: begin
               r_cnt   <= '0;
               r_state <= S_WAIT;
            end

            S_WAIT: begin
               r_cnt <= r_cnt + c_CNT_ONE;
               if (f_valid) begin
                  if (w_match) begin
                     r_term     <= f_out;
                     r_term_idx <= r_acc;
                     r_strobe   <= 1'b1;
                     r_exp_a    <= r_exp_b;
                     r_exp_b    <= w_sum;
                     r_acc      <= r_acc + 5'd1;
                     r_cnt      <= '0;
                     r_state    <= (r_acc == c_LAST_IDX) ? S_DONE : S_PACE;
                  end else begin
                     r_seq   <= 1'b1;
                     r_state <= S_ERR;
                  end
               end else if (r_cnt == c_TMO_LAST) begin
                  r_tmo   <= 1'b1;
                  r_state <= S_ERR;
               end
            end

            S_PACE: begin
               if (r_cnt == c_PACE_LAST) begin
                  r_state <= S_REQ;
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Status outputs are decoded from state so busy falls on the same edge
   // that done or an error flag rises.
   assign f_en        = (r_state == S_REQ);
   assign busy        = (r_state == S_PACE) || (r_state == S_REQ) || (r_state == S_WAIT);
   assign done        = (r_state == S_DONE);
   assign seq_err     = (r_state == S_ERR) && r_seq;
   assign timeout_err = (r_state == S_ERR) && r_tmo;
   assign proto_err   = r_proto;
   assign term        = r_term;
   assign term_idx    = r_term_idx;
   assign term_strobe = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_fib_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_fib_sink
// Description : Self-checking bench for fib_sink. A behavioural generator
//               answers f_en requests with randomized latency; expected terms
//               come from a Fibonacci table computed by plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_sink;

   localparam int c_PACE     = 3;
   localparam int c_TMO      = 8;
   localparam int c_WAIT_LIM = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        f_valid = 1'b0;
   logic [15:0] f_out = 16'd0;
   logic        f_en;
   logic [15:0] term;
   logic [4:0]  term_idx;
   logic        term_strobe;
   logic        busy;
   logic        done;
   logic        seq_err;
   logic        timeout_err;
   logic        proto_err;

   int          n_cmp = 0;
   int          n_bad = 0;
   int unsigned fib [0:24];

   fib_sink #(
      .PACE_CYCLES    (c_PACE),
      .TIMEOUT_CYCLES (c_TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .f_valid     (f_valid),
      .f_out       (f_out),
      .f_en        (f_en),
      .term        (term),
      .term_idx    (term_idx),
      .term_strobe (term_strobe),
      .busy        (busy),
      .done        (done),
      .seq_err     (seq_err),
      .timeout_err (timeout_err),
      .proto_err   (proto_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic wait_fen(output int k);
      k = 0;
      while (f_en !== 1'b1 && k < c_WAIT_LIM) begin
         @(negedge clk);
         k++;
      end
   endtask

   // Called in the negedge of the request cycle; answers lat cycles later.
   task automatic answer(input int lat, input logic [15:0] val);
      repeat (lat) @(negedge clk);
      f_valid = 1'b1;
      f_out   = val;
      @(negedge clk);
      f_valid = 1'b0;
      f_out   = 16'($urandom);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [28:0] obs;
      start   = 1'b1;
      f_valid = 1'b1;
      repeat (3) @(negedge clk);
      obs = {f_en, term, term_idx, term_strobe, busy, done, seq_err, timeout_err, proto_err};
      n_cmp++;
      if (obs !== 29'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h want 0", obs);
      end
      rst     = 1'b0;
      start   = 1'b0;
      f_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (f_en !== 1'b0 || busy !== 1'b0 || proto_err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_idle: f_en=%b busy=%b proto=%b want 0 0 0", f_en, busy, proto_err);
      end
   endtask

   task automatic test_full_run(input bit rnd);
      int k;
      int lat;
      bit extra;
      pulse_start();
      n_cmp++;
      if (f_en !== 1'b1) begin
         n_bad++;
         $display("FAIL restart_latency: f_en=%b want 1", f_en);
      end
      for (int i = 0; i < 25; i++) begin
         wait_fen(k);
         n_cmp++;
         if (f_en !== 1'b1) begin
            n_bad++;
            $display("FAIL full_req idx=%0d: no f_en within %0d cycles", i, k);
            return;
         end
         if (!rnd && i > 0) begin
            n_cmp++;
            if (k !== c_PACE) begin
               n_bad++;
               $display("FAIL req_spacing idx=%0d: got %0d want %0d", i, k, c_PACE);
            end
         end
         lat = rnd ? ((i == 5) ? c_TMO : int'($urandom_range(1, c_TMO))) : 1;
         answer(lat, 16'(fib[i]));
         n_cmp++;
         if (term_strobe !== 1'b1 || term !== 16'(fib[i]) || term_idx !== 5'(i)) begin
            n_bad++;
            $display("FAIL full_term idx=%0d: strobe=%b term=%0d idx=%0d want 1 %0d %0d",
                     i, term_strobe, term, term_idx, fib[i], i);
         end
         n_cmp++;
         if (busy !== (i != 24) || done !== (i == 24)) begin
            n_bad++;
            $display("FAIL full_status idx=%0d: busy=%b done=%b want %b %b",
                     i, busy, done, (i != 24), (i == 24));
         end
      end
      extra = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (f_en === 1'b1) extra = 1'b1;
      end
      n_cmp++;
      if (extra !== 1'b0 || done !== 1'b1 || term_strobe !== 1'b0 || term !== 16'd46368) begin
         n_bad++;
         $display("FAIL full_end: extra_fen=%b done=%b strobe=%b term=%0d want 0 1 0 46368",
                  extra, done, term_strobe, term);
      end
   endtask

   task automatic test_seq_err();
      logic [15:0] vals [5];
      int k;
      vals = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd4};
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         wait_fen(k);
         answer(int'($urandom_range(1, c_TMO)), vals[i]);
         if (i < 4) begin
            n_cmp++;
            if (term_strobe !== 1'b1 || term !== vals[i]) begin
               n_bad++;
               $display("FAIL seq_pre idx=%0d: strobe=%b term=%0d want 1 %0d", i, term_strobe, term, vals[i]);
            end
         end
      end
      n_cmp++;
      if (seq_err !== 1'b1 || timeout_err !== 1'b0 || busy !== 1'b0 || term_strobe !== 1'b0) begin
         n_bad++;
         $display("FAIL seq_flags: seq=%b tmo=%b busy=%b strobe=%b want 1 0 0 0",
                  seq_err, timeout_err, busy, term_strobe);
      end
      n_cmp++;
      if (term !== 16'd2 || term_idx !== 5'd3) begin
         n_bad++;
         $display("FAIL seq_hold: term=%0d idx=%0d want 2 3", term, term_idx);
      end
   endtask

   task automatic test_timeout();
      int k;
      pulse_start();
      n_cmp++;
      if (seq_err !== 1'b0) begin
         n_bad++;
         $display("FAIL start_clears_seq: seq=%b want 0", seq_err);
      end
      for (int i = 0; i < 2; i++) begin
         wait_fen(k);
         answer(int'($urandom_range(1, c_TMO)), 16'(fib[i]));
      end
      wait_fen(k);
      repeat (c_TMO) @(negedge clk);
      n_cmp++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL tmo_early: tmo=%b busy=%b want 0 1", timeout_err, busy);
      end
      @(negedge clk);
      n_cmp++;
      if (timeout_err !== 1'b1 || seq_err !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL tmo_flag: tmo=%b seq=%b busy=%b want 1 0 0", timeout_err, seq_err, busy);
      end
      n_cmp++;
      if (term_idx !== 5'd1 || term !== 16'd1) begin
         n_bad++;
         $display("FAIL tmo_hold: term=%0d idx=%0d want 1 1", term, term_idx);
      end
   endtask

   task automatic test_proto();
      int k;
      pulse_start();
      n_cmp++;
      if (timeout_err !== 1'b0 || proto_err !== 1'b0) begin
         n_bad++;
         $display("FAIL start_clears_tmo: tmo=%b proto=%b want 0 0", timeout_err, proto_err);
      end
      for (int i = 0; i < 25; i++) begin
         wait_fen(k);
         answer(int'($urandom_range(1, c_TMO)), 16'(fib[i]));
         n_cmp++;
         if (term !== 16'(fib[i]) || term_idx !== 5'(i)) begin
            n_bad++;
            $display("FAIL proto_term idx=%0d: term=%0d idx=%0d want %0d %0d", i, term, term_idx, fib[i], i);
         end
         if (i == 0) begin
            f_valid = 1'b1;
            f_out   = 16'($urandom);
            @(negedge clk);
            f_valid = 1'b0;
            n_cmp++;
            if (proto_err !== 1'b1 || busy !== 1'b1) begin
               n_bad++;
               $display("FAIL proto_set: proto=%b busy=%b want 1 1", proto_err, busy);
            end
         end
      end
      n_cmp++;
      if (proto_err !== 1'b1 || done !== 1'b1) begin
         n_bad++;
         $display("FAIL proto_sticky: proto=%b done=%b want 1 1", proto_err, done);
      end
      pulse_start();
      n_cmp++;
      if (proto_err !== 1'b0) begin
         n_bad++;
         $display("FAIL proto_clear: proto=%b want 0", proto_err);
      end
   endtask

   task automatic test_rst_mid_wait();
      int k;
      logic [28:0] obs;
      pulse_rst();
      pulse_start();
      for (int i = 0; i < 10; i++) begin
         wait_fen(k);
         answer(1, 16'(fib[i]));
      end
      wait_fen(k);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      obs = {f_en, term, term_idx, term_strobe, busy, done, seq_err, timeout_err, proto_err};
      n_cmp++;
      if (obs !== 29'd0) begin
         n_bad++;
         $display("FAIL rst_mid_wait: got %h want 0", obs);
      end
      @(negedge clk);
      n_cmp++;
      if (f_en !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_stays_idle: f_en=%b busy=%b want 0 0", f_en, busy);
      end
      pulse_start();
      answer(1, 16'd0);
      n_cmp++;
      if (term_strobe !== 1'b1 || term !== 16'd0 || term_idx !== 5'd0 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_restart: strobe=%b term=%0d idx=%0d busy=%b want 1 0 0 1",
                  term_strobe, term, term_idx, busy);
      end
   endtask

   task automatic test_start_held();
      int k;
      pulse_rst();
      start = 1'b1;
      for (int i = 0; i < 25; i++) begin
         wait_fen(k);
         answer(1, 16'(fib[i]));
      end
      n_cmp++;
      if (done !== 1'b1 || f_en !== 1'b0 || term_idx !== 5'd24) begin
         n_bad++;
         $display("FAIL held_done: done=%b f_en=%b idx=%0d want 1 0 24", done, f_en, term_idx);
      end
      @(negedge clk);
      n_cmp++;
      if (f_en !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL held_restart: f_en=%b done=%b busy=%b want 1 0 1", f_en, done, busy);
      end
      answer(1, 16'd0);
      n_cmp++;
      if (term_strobe !== 1'b1 || term !== 16'd0 || term_idx !== 5'd0) begin
         n_bad++;
         $display("FAIL held_first: strobe=%b term=%0d idx=%0d want 1 0 0", term_strobe, term, term_idx);
      end
      start = 1'b0;
   endtask

   initial begin
      fib[0] = 0;
      fib[1] = 1;
      for (int i = 2; i < 25; i++) fib[i] = fib[i-1] + fib[i-2];

      @(negedge clk);
      test_reset();
      test_full_run(1'b0);
      test_full_run(1'b1);
      test_seq_err();
      test_timeout();
      test_proto();
      test_rst_mid_wait();
      test_start_held();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
